argmax_readout: RTL
===================

# argmax_readout

Final stage of the GNN inference pipeline. Once the combination block asserts `done_comb`, this block walks the combination block's row-read port from row 0 to FEATURE_ROWS-1 and samples each row of adjacency-aggregated dot products. For each node it computes the class index of the maximum value. The per-node class indices are published both as a registered result array and as a per-row valid strobe, so the bench can compare them against the gold address file.

## Interface
Parameters:
- FEATURE_ROWS, 6, number of nodes (rows read from the combination block)
- WEIGHT_COLS, 3, number of classes (elements per row)
- DOT_PROD_WIDTH, 16, width of each row element, unsigned
- MAX_ADDRESS_WIDTH, 2, width of a class index; must satisfy 2^MAX_ADDRESS_WIDTH >= WEIGHT_COLS
- ROW_BW, 3, width of the row index; must satisfy 2^ROW_BW >= FEATURE_ROWS

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- done_comb  in  1  combination block finished; level signal
- adj_fm_wm_row  in  DOT_PROD_WIDTH x [0:WEIGHT_COLS-1]  row data from the combination block, combinational in `read_row`
- read_row  out  ROW_BW  row index presented to the combination block
- max_addi_answer  out  MAX_ADDRESS_WIDTH x [0:FEATURE_ROWS-1]  argmax class index per node
- result_valid  out  1  one-cycle strobe, one per processed row
- result_row  out  ROW_BW  row index qualified by result_valid
- result_addr  out  MAX_ADDRESS_WIDTH  argmax index qualified by result_valid
- done  out  1  all rows processed; held high until re-armed

## Operation
- State machine has three states: IDLE, SCAN, DONE.
- IDLE:
  - `read_row` = 0.
  - On a rising edge of `done_comb` (sampled high while the registered previous value is low), go to SCAN with the row counter at 0.
- SCAN:
  - `read_row` = row counter.
  - Each cycle, sample `adj_fm_wm_row` combinationally and compute the argmax over indices 0..WEIGHT_COLS-1.
  - Comparison is unsigned, full DOT_PROD_WIDTH.
  - Tie-break: the lowest index wins (strict greater-than is required to replace the running maximum).
  - Registered at the clock edge: `max_addi_answer[row]`, `result_valid`=1, `result_row`=row, `result_addr`=index. The counter then increments.
  - After the row FEATURE_ROWS-1 edge, go to DONE. `done` is asserted at that same edge.
- DONE:
  - `done`=1, `result_valid`=0, `read_row` holds 0.
  - `max_addi_answer` holds its values.
  - On a new rising edge of `done_comb`, go back to SCAN, clear `done` at that edge, and restart at row 0. Array entries are overwritten as rows are rescanned.
- A `done_comb` edge arriving while in SCAN is ignored. The scan in progress completes unchanged.
- `done_comb` falling while in SCAN has no effect.

## Timing
- Reset values (synchronous, applied on a clock edge with `rst`=1):
  - State IDLE, counter 0.
  - `read_row`=0, `done`=0, `result_valid`=0, `result_row`=0, `result_addr`=0.
  - All `max_addi_answer` entries 0.
  - Edge-detect register cleared to 0. A `done_comb` already high when reset releases therefore counts as a rising edge on the first cycle after reset.
- Latency:
  - Edge N: `done_comb` seen rising, state goes to SCAN.
  - Edges N+1 .. N+FEATURE_ROWS: one row result per edge.
  - `done` rises at edge N+FEATURE_ROWS, together with the last `result_valid`.
  - Throughput is one row per cycle, with no bubbles.
- `result_valid` is never high in IDLE or DONE. Exactly FEATURE_ROWS strobes are issued per scan.
- Reset during SCAN aborts the scan. All outputs return to reset values on that edge, and a new `done_comb` rising edge is required to start again.

## Test plan
- Reset then basic scan: rows {(5,9,2),(7,1,3),(0,0,8),(4,4,1),(10,2,11),(1,6,6)}, pulse `done_comb` -> `result_addr` sequence 1,0,2,0,2,1; `done` high 6 cycles after the edge; `max_addi_answer` = {1,0,2,0,2,1}.
- Ties: row (3,3,3) -> 0; row (0,7,7) -> 1; row (0xFFFF,0xFFFF,0) -> 0.
- Unsigned extremes: row (0x7FFF,0x8000,0x0001) -> 1; row (0,0,0) -> 0.
- `done_comb` held high across DONE, then dropped and raised again -> exactly one extra scan of 6 strobes; `done` low during the rescan and high again at its end.
- `rst` asserted at the 3rd SCAN cycle -> next edge has all outputs at 0; no further strobes until a new `done_comb` edge; the following full scan yields correct results.
- `done_comb` toggled low then high during SCAN -> ignored; exactly 6 strobes in row order 0..5.

Source files
------------

// File: rtl/argmax_readout.sv
// Walks the combination block's rows after done_comb rises and publishes
// the per-node argmax class index (lowest index wins on ties).
module argmax_readout #(
  parameter int FEATURE_ROWS      = 6,
  parameter int WEIGHT_COLS       = 3,
  parameter int DOT_PROD_WIDTH    = 16,
  parameter int MAX_ADDRESS_WIDTH = 2,
  parameter int ROW_BW            = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         done_comb,
  input  logic [DOT_PROD_WIDTH-1:0]    adj_fm_wm_row [0:WEIGHT_COLS-1],
  output logic [ROW_BW-1:0]            read_row,
  output logic [MAX_ADDRESS_WIDTH-1:0] max_addi_answer [0:FEATURE_ROWS-1],
  output logic                         result_valid,
  output logic [ROW_BW-1:0]            result_row,
  output logic [MAX_ADDRESS_WIDTH-1:0] result_addr,
  output logic                         done
);

  // state | meaning
  // IDLE  | waiting for first done_comb rising edge
  // SCAN  | one row per cycle, read_row is the row counter
  // DONE  | results held, done high, waiting for a new done_comb edge
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [ROW_BW-1:0] LAST_ROW = ROW_BW'(FEATURE_ROWS - 1);

  state_t                         state;
  logic                           done_comb_q;
  logic                           comb_rise;
  logic [DOT_PROD_WIDTH-1:0]      best_val;
  logic [MAX_ADDRESS_WIDTH-1:0]   best_idx;

  assign comb_rise = done_comb & ~done_comb_q;

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    best_val = adj_fm_wm_row[0];
    best_idx = '0;
    for (int i = 1; i < WEIGHT_COLS; i++) begin
      if (adj_fm_wm_row[i] > best_val) begin
        best_val = adj_fm_wm_row[i];
        best_idx = MAX_ADDRESS_WIDTH'(i);
      end
    end
  end

  // read_row doubles as the row counter; it is held at 0 outside SCAN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      done_comb_q  <= 1'b0;
      read_row     <= '0;
      result_valid <= 1'b0;
      result_row   <= '0;
      result_addr  <= '0;
      done         <= 1'b0;
      for (int i = 0; i < FEATURE_ROWS; i++) max_addi_answer[i] <= '0;
    end else begin
      done_comb_q  <= done_comb;
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          read_row <= '0;
          if (comb_rise) state <= SCAN;
        end
        SCAN: begin
          max_addi_answer[read_row] <= best_idx;
          result_valid <= 1'b1;
          result_row   <= read_row;
          result_addr  <= best_idx;
          if (read_row == LAST_ROW) begin
            state    <= DONE;
            done     <= 1'b1;
            read_row <= '0;
          end else begin
            read_row <= read_row + 1'b1;
          end
        end
        DONE: begin
          read_row <= '0;
          if (comb_rise) begin
            state <= SCAN;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
